// File: rtl/data_bus_skid_buffer.sv
// data_bus_skid_buffer: registered valid/ready bus stage with a
// 2-entry skid buffer, synchronous flush and an output transfer counter.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   flush     synchronous drop of buffered words (counter kept)
//   dataIn    upstream word, qualified by validIn
//   validIn   upstream word valid
//   readyOut  stage can take a word this cycle (from flops)
//   dataOut   downstream word (from flops), qualified by validOut
//   validOut  dataOut valid (from flops)
//   readyIn   downstream can take a word this cycle
//   xferCount completed output transfers, wraps silently
module data_bus_skid_buffer #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic [WIDTH-1:0]     dataIn,
   input  logic                 validIn,
   output logic                 readyOut,
   output logic [WIDTH-1:0]     dataOut,
   output logic                 validOut,
   input  logic                 readyIn,
   output logic [CNT_WIDTH-1:0] xferCount
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;
   logic             acc;
   logic             xfer;

   // Handshake outputs decode only the state flops, so neither
   // readyIn nor validIn reaches them combinationally.
   assign validOut = (state != EMPTY);
   assign readyOut = (state != FULL);
   assign dataOut  = main_q;

   assign acc  = validIn && readyOut;
   assign xfer = validOut && readyIn;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   always_comb begin
      state_nxt = state;
      main_d    = main_q;
      skid_d    = skid_q;
      unique case (state)
         EMPTY: begin
            if (acc) begin
               main_d    = dataIn;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (acc && xfer) begin
               main_d = dataIn;
            end else if (acc) begin
               skid_d    = dataIn;
               state_nxt = FULL;
            end else if (xfer) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (xfer) begin
               main_d    = skid_q;
               state_nxt = BUSY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush wins: drop the words but leave the data flops alone,
      // so dataOut keeps showing the last word it held.
      if (flush) begin
         state_nxt = EMPTY;
         main_d    = main_q;
         skid_d    = skid_q;
      end
   end

   // A transfer on a flush cycle still happened downstream, so count it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xferCount <= '0;
      end else if (xfer) begin
         xferCount <= xferCount + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_data_bus_skid_buffer.sv
// tb_data_bus_skid_buffer: table vectors, corner sequences and
// random traffic against a queue model of the skid buffer.
module tb_data_bus_skid_buffer;

   localparam int W = 4;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic         flush   = 1'b0;
   logic         validIn = 1'b0;
   logic         readyIn = 1'b0;
   logic [W-1:0] dataIn  = '0;

   logic         readyOut;
   logic         validOut;
   logic [W-1:0] dataOut;
   logic [15:0]  xferCount;
   logic         readyOut_w;
   logic         validOut_w;
   logic [W-1:0] dataOut_w;
   logic [2:0]   xferCount_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_bus_skid_buffer #(.WIDTH(W), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .dataIn(dataIn), .validIn(validIn), .readyOut(readyOut),
      .dataOut(dataOut), .validOut(validOut), .readyIn(readyIn),
      .xferCount(xferCount)
   );

   data_bus_skid_buffer #(.WIDTH(W), .CNT_WIDTH(3)) dut_w (
      .clk(clk), .reset(reset), .flush(flush),
      .dataIn(dataIn), .validIn(validIn), .readyOut(readyOut_w),
      .dataOut(dataOut_w), .validOut(validOut_w), .readyIn(readyIn),
      .xferCount(xferCount_w)
   );

   // Model: the stage is a FIFO of at most two words.
   logic [W-1:0] mq[$];
   logic [W-1:0] mlast;
   int unsigned  mcnt;

   typedef struct packed {
      logic         f;
      logic         v;
      logic [W-1:0] d;
      logic         r;
      logic         ev;
      logic         er;
      logic [W-1:0] ed;
      int           ec;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mlast = '0;
      mcnt  = 0;
   endtask

   task automatic model_step();
      bit x;
      bit a;
      x = (mq.size() > 0) && readyIn;
      a = validIn && (mq.size() < 2);
      if (x) mcnt++;
      if (flush) begin
         if (mq.size() > 0) mlast = mq[0];
         mq.delete();
      end else begin
         if (x) mlast = mq.pop_front();
         if (a) mq.push_back(dataIn);
      end
   endtask

   task automatic check_model();
      logic         mv;
      logic         mr;
      logic [W-1:0] md;
      mv = (mq.size() > 0);
      mr = (mq.size() < 2);
      md = mv ? mq[0] : mlast;
      chk("validOut", 32'(validOut), 32'(mv));
      chk("readyOut", 32'(readyOut), 32'(mr));
      chk("dataOut", 32'(dataOut), 32'(md));
      chk("xferCount", 32'(xferCount), 32'(16'(mcnt)));
      chk("validOut_w", 32'(validOut_w), 32'(mv));
      chk("readyOut_w", 32'(readyOut_w), 32'(mr));
      chk("dataOut_w", 32'(dataOut_w), 32'(md));
      chk("xferCount_w", 32'(xferCount_w), 32'(3'(mcnt)));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) model_reset();
      else model_step();
      #1;
      check_model();
   endtask

   task automatic drive(logic f, logic v, logic [W-1:0] d, logic r);
      flush   = f;
      validIn = v;
      dataIn  = d;
      readyIn = r;
   endtask

   task automatic add(logic f, logic v, logic [W-1:0] d, logic r,
                      logic ev, logic er, logic [W-1:0] ed, int ec);
      vec_t t;
      t = '{f: f, v: v, d: d, r: r, ev: ev, er: er, ed: ed, ec: ec};
      tbl.push_back(t);
   endtask

   task automatic check_reset_vals(string nm);
      chk({nm, ".validOut"}, 32'(validOut), 32'd0);
      chk({nm, ".readyOut"}, 32'(readyOut), 32'd1);
      chk({nm, ".dataOut"}, 32'(dataOut), 32'd0);
      chk({nm, ".xferCount"}, 32'(xferCount), 32'd0);
      chk({nm, ".xferCount_w"}, 32'(xferCount_w), 32'd0);
   endtask

   initial begin
      // single word, then streaming 1..8
      add(0, 1, 4'hA, 1, 1, 1, 4'hA, 0);
      add(0, 0, 4'h0, 1, 0, 1, 4'hA, 1);
      for (int k = 1; k <= 8; k++)
         add(0, 1, W'(k), 1, 1, 1, W'(k), k);
      add(0, 0, 4'h0, 1, 0, 1, 4'h8, 9);
      // backpressure: 3, 5 fill, 7 waits
      add(0, 1, 4'h3, 0, 1, 1, 4'h3, 9);
      add(0, 1, 4'h5, 0, 1, 0, 4'h3, 9);
      add(0, 1, 4'h7, 0, 1, 0, 4'h3, 9);
      add(0, 1, 4'h7, 1, 1, 1, 4'h5, 10);
      add(0, 1, 4'h7, 1, 1, 1, 4'h7, 11);
      add(0, 0, 4'h0, 1, 0, 1, 4'h7, 12);
      // flush while full, 9 offered on the flush cycle
      add(0, 1, 4'h1, 0, 1, 1, 4'h1, 12);
      add(0, 1, 4'h2, 0, 1, 0, 4'h1, 12);
      add(1, 1, 4'h9, 0, 0, 1, 4'h1, 12);
      add(0, 0, 4'h0, 1, 0, 1, 4'h1, 12);

      model_reset();
      drive(0, 1, 4'hF, 1);
      #1;
      check_reset_vals("rst_async");
      for (int i = 0; i < 4; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1),
               W'($urandom), $urandom_range(0, 1));
         tick();
         check_reset_vals($sformatf("rst%0d", i));
      end
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
         tick();
         chk($sformatf("tbl%0d.validOut", i), 32'(validOut),
             32'(tbl[i].ev));
         chk($sformatf("tbl%0d.readyOut", i), 32'(readyOut),
             32'(tbl[i].er));
         chk($sformatf("tbl%0d.dataOut", i), 32'(dataOut),
             32'(tbl[i].ed));
         chk($sformatf("tbl%0d.xferCount", i), 32'(xferCount),
             32'(tbl[i].ec));
         chk($sformatf("tbl%0d.xferCount_w", i), 32'(xferCount_w),
             32'(tbl[i].ec % 8));
      end

      // counter wrap on the 3-bit instance
      reset = 1'b0;
      #2;
      model_reset();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, W'(i + 1), 1);
         tick();
         if (i >= 1)
            chk($sformatf("wrap%0d", i), 32'(xferCount_w),
                32'(i % 8));
      end
      drive(0, 0, 4'h0, 1);
      tick();

      // async reset while full
      drive(0, 1, 4'h4, 0);
      tick();
      drive(0, 1, 4'h6, 0);
      tick();
      chk("full.readyOut", 32'(readyOut), 32'd0);
      reset = 1'b0;
      #1;
      check_reset_vals("midrst");
      model_reset();
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 4'h0, 1);
         tick();
         chk($sformatf("midrst_after%0d.validOut", i),
             32'(validOut), 32'd0);
         chk($sformatf("midrst_after%0d.dataOut", i),
             32'(dataOut), 32'd0);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
               W'($urandom), $urandom_range(0, 2) != 0);
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_model();
            reset = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
